irq_encoder_8to3: RTL and testbench

Registered 8-to-3 priority request encoder: the return path for the 3-to-8 active-low decoder. It captures falling edges on eight active-low request lines, holds them as pending, and presents the highest-priority pending index as a 3-bit {C, B, A} code over a valid/ack handshake. Line numbering matches the decoder: a low on `req_n[7-i]` requests code i.

---
 rtl/irq_encoder_8to3.sv | 89 ++++++++
 tb/tb_irq_encoder_8to3.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_encoder_8to3.sv
// irq_encoder_8to3: registered 8-to-3 priority request encoder with valid/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   G          : active-low present enable (sampled in IDLE only)
//   req_n[7:0] : active-low asynchronous requests, req_n[7] is code 0
//   ack        : consumer accepts the presented code while valid
//   C, B, A    : registered code, C is the MSB
//   valid      : code is presented and awaiting ack
//   any_n      : registered, low while any request is pending
//   pend[7:0]  : pending requests, same bit order as req_n
//   ovf        : sticky, an edge arrived on an already pending line
module irq_encoder_8to3 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       G,
   input  logic [7:0] req_n,
   input  logic       ack,
   output logic       C,
   output logic       B,
   output logic       A,
   output logic       valid,
   output logic       any_n,
   output logic [7:0] pend,
   output logic       ovf
);
   typedef enum logic {IDLE, PRESENT} state_t;
   localparam logic [2:0] ARM = 3'(SYNC_STAGES + 1);
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0] prev_q, pend_q, pend_d, fell, clr;
   logic [2:0] code_q, code_d, top_code, flush_q;
   logic       ovf_q, ovf_d, any_n_q, armed;
   // Synchronizer and prev flops reset high so the lines read idle after reset.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_n};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   // Edges stay masked until the post-reset idle-high values have flushed
   // through sync and prev, so a line held low across reset does not re-fire.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) flush_q <= '0;
      else        flush_q <= armed ? flush_q : flush_q + 3'd1;
   assign armed = flush_q == ARM;
   assign fell  = armed ? (~sync_q[SYNC_STAGES-1] & prev_q) : '0;
   assign clr   = (state_q == PRESENT && ack) ? (8'h80 >> code_q) : '0;
   // Set wins over clear on the same bit.
   assign pend_d = (pend_q & ~clr) | fell;
   assign ovf_d  = ovf_q | (|(fell & pend_q & ~clr));
   // Highest index wins, which is the lowest code.
   always_comb begin
      top_code = '0;
      for (int i = 0; i < 8; i++)
         if (pend_q[i]) top_code = 3'(7 - i);
   end
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      if (state_q == IDLE) begin
         state_d = (!G && |pend_q) ? PRESENT : IDLE;
         code_d  = (!G && |pend_q) ? top_code : code_q;
      end else begin
         state_d = ack ? IDLE : PRESENT;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         any_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         any_n_q <= ~|pend_q;
      end
   assign {C, B, A} = code_q;
   assign valid     = state_q == PRESENT;
   assign any_n     = any_n_q;
   assign pend      = pend_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_irq_encoder_8to3.sv
// tb_irq_encoder_8to3: scoreboard bench for irq_encoder_8to3.
module tb_irq_encoder_8to3;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       G = 1'b0;
   logic [7:0] req_n = 8'hFF;
   logic       ack = 1'b0;
   logic       C, B, A, valid, any_n, ovf;
   logic [7:0] pend;
   logic [2:0] cba;
   logic [2:0] exp_q[$];
   logic [2:0] exp_code;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   irq_encoder_8to3 dut (
      .clk(clk), .rst_n(rst_n), .G(G), .req_n(req_n), .ack(ack),
      .C(C), .B(B), .A(A), .valid(valid), .any_n(any_n), .pend(pend), .ovf(ovf)
   );

   assign cba = {C, B, A};
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      req_n = 8'hFF;
      repeat (4) tick();
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 10 && valid !== 1'b1; i++) tick();
      total_cnt++;
      if (valid !== 1'b1) $display("FAIL wait_valid: valid=%b want 1 within 10 cycles", valid);
      else pass_cnt++;
   endtask

   task automatic pop_check(input string name);
      exp_code = exp_q.pop_front();
      total_cnt++;
      if (valid !== 1'b1 || cba !== exp_code)
         $display("FAIL %s: valid=%b code=%b want valid=1 code=%b", name, valid, cba, exp_code);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      int seen;
      #12 rst_n = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({cba, valid, any_n, pend, ovf} !== {3'b000, 1'b0, 1'b1, 8'h00, 1'b0})
         $display("FAIL reset_values: cba=%b valid=%b any_n=%b pend=%h ovf=%b want 000 0 1 00 0",
                  cba, valid, any_n, pend, ovf);
      else pass_cnt++;
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (valid === 1'b1) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL reset_quiet: valid seen %0d times want 0", seen);
      else pass_cnt++;
   endtask

   task automatic test_single();
      req_n = 8'hDF;
      exp_q.push_back(3'd2);
      repeat (3) tick();
      total_cnt++;
      if ({valid, pend, any_n} !== {1'b0, 8'h20, 1'b1})
         $display("FAIL single_edge3: valid=%b pend=%h any_n=%b want 0 20 1", valid, pend, any_n);
      else pass_cnt++;
      tick();
      pop_check("single_edge4");
      total_cnt++;
      if (any_n !== 1'b0) $display("FAIL single_any_n: any_n=%b want 0", any_n);
      else pass_cnt++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({valid, pend} !== {1'b0, 8'h00})
         $display("FAIL single_ack: valid=%b pend=%h want 0 00", valid, pend);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (any_n !== 1'b1) $display("FAIL single_any_n_rise: any_n=%b want 1", any_n);
      else pass_cnt++;
      settle();
   endtask

   task automatic test_back_to_back();
      req_n = 8'hBE;
      ack = 1'b1;
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd7);
      wait_valid();
      pop_check("b2b_first");
      tick();
      total_cnt++;
      if (valid !== 1'b0) $display("FAIL b2b_gap: valid=%b want 0", valid);
      else pass_cnt++;
      tick();
      pop_check("b2b_second");
      tick();
      total_cnt++;
      if ({valid, pend} !== {1'b0, 8'h00})
         $display("FAIL b2b_drain: valid=%b pend=%h want 0 00", valid, pend);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (any_n !== 1'b1) $display("FAIL b2b_any_n: any_n=%b want 1", any_n);
      else pass_cnt++;
      ack = 1'b0;
      settle();
   endtask

   task automatic test_enable();
      G = 1'b1;
      req_n = 8'h7F;
      repeat (6) tick();
      total_cnt++;
      if ({valid, pend} !== {1'b0, 8'h80})
         $display("FAIL enable_gated: valid=%b pend=%h want 0 80", valid, pend);
      else pass_cnt++;
      G = 1'b0;
      exp_q.push_back(3'd0);
      tick();
      pop_check("enable_drop");
      G = 1'b1;
      exp_q.push_back(3'd0);
      repeat (2) tick();
      pop_check("enable_hold");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({valid, pend} !== {1'b0, 8'h00})
         $display("FAIL enable_ack: valid=%b pend=%h want 0 00", valid, pend);
      else pass_cnt++;
      G = 1'b0;
      settle();
   endtask

   task automatic test_collision();
      req_n = 8'hDF;
      exp_q.push_back(3'd2);
      wait_valid();
      pop_check("coll_first");
      settle();
      req_n = 8'hDF;
      repeat (2) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({valid, pend, ovf} !== {1'b0, 8'h20, 1'b0})
         $display("FAIL coll_setwins: valid=%b pend=%h ovf=%b want 0 20 0", valid, pend, ovf);
      else pass_cnt++;
      exp_q.push_back(3'd2);
      tick();
      pop_check("coll_again");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({valid, pend} !== {1'b0, 8'h00})
         $display("FAIL coll_drain: valid=%b pend=%h want 0 00", valid, pend);
      else pass_cnt++;
      settle();
   endtask

   task automatic test_ovf();
      G = 1'b1;
      req_n = 8'hDF;
      repeat (4) tick();
      total_cnt++;
      if ({pend, ovf} !== {8'h20, 1'b0})
         $display("FAIL ovf_before: pend=%h ovf=%b want 20 0", pend, ovf);
      else pass_cnt++;
      settle();
      req_n = 8'hDF;
      repeat (4) tick();
      total_cnt++;
      if ({valid, pend, ovf} !== {1'b0, 8'h20, 1'b1})
         $display("FAIL ovf_set: valid=%b pend=%h ovf=%b want 0 20 1", valid, pend, ovf);
      else pass_cnt++;
      G = 1'b0;
      exp_q.push_back(3'd2);
      tick();
      pop_check("ovf_present");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({valid, ovf} !== {1'b0, 1'b1})
         $display("FAIL ovf_sticky: valid=%b ovf=%b want 0 1", valid, ovf);
      else pass_cnt++;
      settle();
   endtask

   task automatic test_reset_mid();
      int seen;
      req_n = 8'h7D;
      exp_q.push_back(3'd0);
      wait_valid();
      pop_check("rmid_present");
      total_cnt++;
      if (pend !== 8'h82) $display("FAIL rmid_pend: pend=%h want 82", pend);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({cba, valid, any_n, pend, ovf} !== {3'b000, 1'b0, 1'b1, 8'h00, 1'b0})
         $display("FAIL rmid_async: cba=%b valid=%b any_n=%b pend=%h ovf=%b want 000 0 1 00 0",
                  cba, valid, any_n, pend, ovf);
      else pass_cnt++;
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (valid === 1'b1 || pend !== 8'h00) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL rmid_refire: %0d cycles with valid or pend set want 0", seen);
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size());
      else pass_cnt++;
      settle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_enable();
      test_collision();
      test_ovf();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
